// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and constants for the memory bus controller:
//               FSM state enum, decoded region enum and the one-hot bus_sel
//               encodings, plus a helper mapping a region to its select.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_ROM  = 2'd1,
    REG_RAM  = 2'd2,
    REG_IO   = 2'd3
  } region_e;

  // bus_sel is {io, ram, rom}
  localparam logic [2:0] c_sel_none = 3'b000;
  localparam logic [2:0] c_sel_rom  = 3'b001;
  localparam logic [2:0] c_sel_ram  = 3'b010;
  localparam logic [2:0] c_sel_io   = 3'b100;

  function automatic logic [2:0] region_sel(input region_e region);
    case (region)
      REG_ROM: return c_sel_rom;
      REG_RAM: return c_sel_ram;
      REG_IO:  return c_sel_io;
      default: return c_sel_none;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl_if
// Description : Shared word-addressed memory bus. The controller is the
//               master (address, data, enables, strobes, region select);
//               the ROM/RAM/IO targets are the slave side (read data, IO
//               ready).
//   bus_addr      30  word address
//   bus_wdata     32  lane-aligned write data
//   bus_be         4  lane-aligned byte enables
//   bus_rd/bus_wr  1  one-cycle access strobes
//   bus_sel        3  one-hot region select {io, ram, rom}
//   bus_rdata_*   32  per-region read data
//   bus_ready_io   1  IO access completion
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_ctrl_if;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rd;
  logic        bus_wr;
  logic [2:0]  bus_sel;
  logic [31:0] bus_rdata_rom;
  logic [31:0] bus_rdata_ram;
  logic [31:0] bus_rdata_io;
  logic        bus_ready_io;

  modport master (
    output bus_addr, bus_wdata, bus_be, bus_rd, bus_wr, bus_sel,
    input  bus_rdata_rom, bus_rdata_ram, bus_rdata_io, bus_ready_io
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_be, bus_rd, bus_wr, bus_sel,
    output bus_rdata_rom, bus_rdata_ram, bus_rdata_io, bus_ready_io
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_lane_align
// Description : Combinational byte-lane alignment between the CPU's
//               right-justified data/mask and the word bus lanes.
//   i_off       2  byte offset within the word
//   i_mask      4  right-justified byte mask
//   i_wdata    32  right-justified write data
//   i_rdata    32  raw word read data from the bus
//   o_be        4  byte enables shifted into lane position
//   o_wdata    32  write data shifted into lane position
//   o_rdata    32  read data shifted down to bit 0, zero-filled
//   o_overflow  1  mask shifted by offset spills past lane 3
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_lane_align (
  input  logic [1:0]  i_off,
  input  logic [3:0]  i_mask,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_overflow
);

  logic [7:0] w_be_wide;
  logic [4:0] w_bit_shift;

  // Shift in a double-width field so bits pushed past lane 3 stay visible
  // as the overflow indication instead of being silently dropped.
  assign w_be_wide   = {4'b0000, i_mask} << i_off;
  assign w_bit_shift = {i_off, 3'b000};

  assign o_be       = w_be_wide[3:0];
  assign o_overflow = |w_be_wide[7:4];
  assign o_wdata    = i_wdata << w_bit_shift;
  assign o_rdata    = i_rdata >> w_bit_shift;

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Terminates CPU memory-access requests. Decodes the byte
//               address into ROM/RAM/IO, aligns data and byte enables to
//               word lanes, drives the shared bus with a one-cycle strobe,
//               waits a fixed latency (ROM/RAM) or for ready (IO, with
//               timeout) and returns a one-cycle ma_done (with ma_err on
//               illegal access or IO timeout).
//   clk, rst          clock, asynchronous active-high reset
//   ma_addr      in   32  CPU byte address
//   ma_data_out  in   32  CPU write data, right-justified
//   ma_data_mask in    4  CPU byte mask, right-justified
//   ma_rd_req    in    1  read request level
//   ma_wr_req    in    1  write request level (wins over read)
//   ma_data_in   out  32  read data, right-justified, zero-filled
//   ma_done      out   1  one-cycle completion pulse
//   ma_err       out   1  one-cycle error pulse, with ma_done
//   bus               master side of mem_bus_ctrl_if
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] ROM_BASE      = 32'h4000_0000,
  parameter int          ROM_SIZE_LOG2 = 14,
  parameter logic [31:0] RAM_BASE      = 32'h0000_0000,
  parameter int          RAM_SIZE_LOG2 = 14,
  parameter logic [31:0] IO_BASE       = 32'h8000_0000,
  parameter int          IO_SIZE_LOG2  = 16,
  parameter int          ROM_LAT       = 1,
  parameter int          RAM_LAT       = 1,
  parameter int          IO_TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   ma_addr,
  input  logic [31:0]   ma_data_out,
  input  logic [3:0]    ma_data_mask,
  input  logic          ma_rd_req,
  input  logic          ma_wr_req,
  output logic [31:0]   ma_data_in,
  output logic          ma_done,
  output logic          ma_err,
  mem_bus_ctrl_if.master bus
);

  localparam logic [31:0] c_rom_mask = 32'((64'd1 << ROM_SIZE_LOG2) - 64'd1);
  localparam logic [31:0] c_ram_mask = 32'((64'd1 << RAM_SIZE_LOG2) - 64'd1);
  localparam logic [31:0] c_io_mask  = 32'((64'd1 << IO_SIZE_LOG2) - 64'd1);
  localparam logic [7:0]  c_rom_lat  = 8'(ROM_LAT);
  localparam logic [7:0]  c_ram_lat  = 8'(RAM_LAT);
  localparam logic [7:0]  c_io_last  = 8'(IO_TIMEOUT - 1);

  state_e      r_state;
  region_e     r_region;
  logic [1:0]  r_off;
  logic        r_is_wr;
  logic [7:0]  r_lat_cnt;
  logic [7:0]  r_tmo_cnt;

  region_e     w_region;
  logic        w_req;
  logic        w_legal;
  logic [1:0]  w_align_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata_raw;
  logic [31:0] w_rdata_aligned;
  logic        w_overflow;
  logic        w_wait_end;
  logic        w_wait_err;

  // --------------------------------------------------------------------------
  // Address decode, ROM first, then RAM, then IO on overlap
  // --------------------------------------------------------------------------
  always_comb begin
    w_region = REG_NONE;
    if ((ma_addr & ~c_rom_mask) == ROM_BASE) begin
      w_region = REG_ROM;
    end else if ((ma_addr & ~c_ram_mask) == RAM_BASE) begin
      w_region = REG_RAM;
    end else if ((ma_addr & ~c_io_mask) == IO_BASE) begin
      w_region = REG_IO;
    end
  end

  assign w_req   = ma_rd_req | ma_wr_req;
  assign w_legal = (w_region != REG_NONE)
                 && !(ma_wr_req && (w_region == REG_ROM))
                 && !w_overflow;

  // --------------------------------------------------------------------------
  // Lane alignment. The aligner is shared: in IDLE it shifts the incoming
  // write data/mask using the live offset; afterwards it unshifts read data
  // using the offset latched at accept.
  // --------------------------------------------------------------------------
  assign w_align_off = (r_state == ST_IDLE) ? ma_addr[1:0] : r_off;

  always_comb begin
    w_rdata_raw = '0;
    case (r_region)
      REG_ROM: w_rdata_raw = bus.bus_rdata_rom;
      REG_RAM: w_rdata_raw = bus.bus_rdata_ram;
      REG_IO:  w_rdata_raw = bus.bus_rdata_io;
      default: w_rdata_raw = '0;
    endcase
  end

  mem_bus_lane_align u_lane_align (
    .i_off      (w_align_off),
    .i_mask     (ma_data_mask),
    .i_wdata    (ma_data_out),
    .i_rdata    (w_rdata_raw),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata_aligned),
    .o_overflow (w_overflow)
  );

  // --------------------------------------------------------------------------
  // WAIT termination: fixed-latency regions finish when the down-counter
  // reads 1; IO finishes on ready, or errors out on its last allowed cycle.
  // Ready on the final cycle still counts as success.
  // --------------------------------------------------------------------------
  always_comb begin
    w_wait_end = 1'b0;
    w_wait_err = 1'b0;
    if (r_region == REG_IO) begin
      if (bus.bus_ready_io) begin
        w_wait_end = 1'b1;
      end else if (r_tmo_cnt == c_io_last) begin
        w_wait_end = 1'b1;
        w_wait_err = 1'b1;
      end
    end else begin
      w_wait_end = (r_lat_cnt == 8'd1);
    end
  end

  // --------------------------------------------------------------------------
  // Controller FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_region      <= REG_NONE;
      r_off         <= '0;
      r_is_wr       <= 1'b0;
      r_lat_cnt     <= '0;
      r_tmo_cnt     <= '0;
      ma_data_in    <= '0;
      ma_done       <= 1'b0;
      ma_err        <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_be    <= '0;
      bus.bus_rd    <= 1'b0;
      bus.bus_wr    <= 1'b0;
      bus.bus_sel   <= c_sel_none;
    end else begin
      // Pulses and read data live for a single cycle only
      ma_done    <= 1'b0;
      ma_err     <= 1'b0;
      ma_data_in <= '0;
      bus.bus_rd <= 1'b0;
      bus.bus_wr <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_legal) begin
              r_region      <= w_region;
              r_off         <= ma_addr[1:0];
              r_is_wr       <= ma_wr_req;
              bus.bus_addr  <= ma_addr[31:2];
              bus.bus_sel   <= region_sel(w_region);
              bus.bus_be    <= w_be;
              bus.bus_wdata <= w_wdata;
              bus.bus_rd    <= ~ma_wr_req;
              bus.bus_wr    <= ma_wr_req;
              r_state       <= ST_STROBE;
            end else begin
              // Rejected without touching the bus
              ma_done <= 1'b1;
              ma_err  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end

        ST_STROBE: begin
          r_lat_cnt <= (r_region == REG_ROM) ? c_rom_lat : c_ram_lat;
          r_tmo_cnt <= '0;
          r_state   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (w_wait_end) begin
            ma_done     <= 1'b1;
            ma_err      <= w_wait_err;
            ma_data_in  <= (r_is_wr || w_wait_err) ? 32'd0 : w_rdata_aligned;
            bus.bus_sel <= c_sel_none;
            bus.bus_be  <= '0;
            r_lat_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_state     <= ST_DONE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 8'd1;
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Self-checking bench for mem_bus_ctrl. Directed cases plus
//               randomized transactions compared against an address-range /
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

  localparam logic [31:0] ROM_BASE   = 32'h4000_0000;
  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] IO_BASE    = 32'h8000_0000;
  localparam longint      ROM_SIZE   = 64'd16384;
  localparam longint      RAM_SIZE   = 64'd16384;
  localparam longint      IO_SIZE    = 64'd65536;
  localparam int          ROM_LAT    = 2;
  localparam int          RAM_LAT    = 1;
  localparam int          IO_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ma_addr = '0;
  logic [31:0] ma_data_out = '0;
  logic [3:0]  ma_data_mask = '0;
  logic        ma_rd_req = 1'b0;
  logic        ma_wr_req = 1'b0;
  logic [31:0] ma_data_in;
  logic        ma_done;
  logic        ma_err;

  int n_chk  = 0;
  int n_pass = 0;
  bit txn_bad;

  mem_bus_ctrl_if bus_if();

  mem_bus_ctrl #(
    .ROM_BASE      (ROM_BASE),
    .ROM_SIZE_LOG2 (14),
    .RAM_BASE      (RAM_BASE),
    .RAM_SIZE_LOG2 (14),
    .IO_BASE       (IO_BASE),
    .IO_SIZE_LOG2  (16),
    .ROM_LAT       (ROM_LAT),
    .RAM_LAT       (RAM_LAT),
    .IO_TIMEOUT    (IO_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ma_addr      (ma_addr),
    .ma_data_out  (ma_data_out),
    .ma_data_mask (ma_data_mask),
    .ma_rd_req    (ma_rd_req),
    .ma_wr_req    (ma_wr_req),
    .ma_data_in   (ma_data_in),
    .ma_done      (ma_done),
    .ma_err       (ma_err),
    .bus          (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      txn_bad = 1'b1;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge (sampling/driving point)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_done"},  {31'd0, ma_done}, 32'd0);
    check_val({tag, "_err"},   {31'd0, ma_err}, 32'd0);
    check_val({tag, "_rd"},    {31'd0, bus_if.bus_rd}, 32'd0);
    check_val({tag, "_wr"},    {31'd0, bus_if.bus_wr}, 32'd0);
    check_val({tag, "_sel"},   {29'd0, bus_if.bus_sel}, 32'd0);
    check_val({tag, "_be"},    {28'd0, bus_if.bus_be}, 32'd0);
    check_val({tag, "_addr"},  {2'd0, bus_if.bus_addr}, 32'd0);
    check_val({tag, "_wdata"}, bus_if.bus_wdata, 32'd0);
    check_val({tag, "_rdata"}, ma_data_in, 32'd0);
  endtask

  task automatic resync();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // One complete CPU transaction, issued in the current cycle (cycle 0).
  // ready_cyc: cycle in which IO ready is driven (0 = never).
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [31:0] raw,
                         input int ready_cyc, input bit drop, input bit glitch);
    longint a;
    int     reg_id;
    int     off;
    int     lanes;
    bit     illegal;
    bit     exp_err;
    int     done_cyc;
    int     cap_cyc;
    logic [2:0]  exp_sel;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_data;

    txn_bad = 1'b0;
    // Reference model: region by address range, alignment by arithmetic
    a = longint'(addr);
    if (a >= longint'(ROM_BASE) && a < longint'(ROM_BASE) + ROM_SIZE)     reg_id = 1;
    else if (a >= longint'(RAM_BASE) && a < longint'(RAM_BASE) + RAM_SIZE) reg_id = 2;
    else if (a >= longint'(IO_BASE) && a < longint'(IO_BASE) + IO_SIZE)    reg_id = 3;
    else                                                                   reg_id = 0;
    off     = int'(addr % 32'd4);
    lanes   = int'(mask) * (1 << off);
    illegal = (reg_id == 0) || (wr && reg_id == 1) || (lanes > 15);
    exp_be    = 4'(lanes % 16);
    exp_wdata = 32'(longint'(data) * longint'(256 ** off));
    exp_rd    = 32'(longint'(raw) / longint'(256 ** off));
    exp_sel   = (reg_id == 1) ? 3'b001 : (reg_id == 2) ? 3'b010 : (reg_id == 3) ? 3'b100 : 3'b000;
    exp_err   = illegal;
    if (illegal)          done_cyc = 1;
    else if (reg_id == 1) done_cyc = 2 + ROM_LAT;
    else if (reg_id == 2) done_cyc = 2 + RAM_LAT;
    else if (ready_cyc >= 2 && ready_cyc <= 1 + IO_TIMEOUT) done_cyc = ready_cyc + 1;
    else begin
      done_cyc = 2 + IO_TIMEOUT;
      exp_err  = 1'b1;
    end
    cap_cyc  = done_cyc - 1;
    exp_data = (exp_err || wr) ? 32'd0 : exp_rd;

    ma_addr      = addr;
    ma_data_mask = mask;
    ma_data_out  = data;
    ma_wr_req    = wr;
    ma_rd_req    = ~wr;
    bus_if.bus_rdata_rom = ~raw;
    bus_if.bus_rdata_ram = ~raw;
    bus_if.bus_rdata_io  = ~raw;
    bus_if.bus_ready_io  = 1'b0;

    for (int c = 1; c <= done_cyc; c++) begin
      step();
      // Valid read data only in the cycle the DUT is meant to capture it
      bus_if.bus_rdata_rom = (reg_id == 1 && c == cap_cyc) ? raw : ~raw;
      bus_if.bus_rdata_ram = (reg_id == 2 && c == cap_cyc) ? raw : ~raw;
      bus_if.bus_rdata_io  = (reg_id == 3 && c == cap_cyc) ? raw : ~raw;
      bus_if.bus_ready_io  = (c == ready_cyc) || (c == 1 && glitch);
      if (drop && c == 1) begin
        ma_rd_req = 1'b0;
        ma_wr_req = 1'b0;
      end
      check_val("done", {31'd0, ma_done}, {31'd0, c == done_cyc});
      check_val("bus_rd", {31'd0, bus_if.bus_rd}, {31'd0, !illegal && c == 1 && !wr});
      check_val("bus_wr", {31'd0, bus_if.bus_wr}, {31'd0, !illegal && c == 1 && wr});
      if (!illegal && c < done_cyc) begin
        check_val("bus_addr",  {2'd0, bus_if.bus_addr}, {2'd0, addr[31:2]});
        check_val("bus_sel",   {29'd0, bus_if.bus_sel}, {29'd0, exp_sel});
        check_val("bus_be",    {28'd0, bus_if.bus_be}, {28'd0, exp_be});
        check_val("bus_wdata", bus_if.bus_wdata, exp_wdata);
      end
      if (c == done_cyc) begin
        check_val("err", {31'd0, ma_err}, {31'd0, exp_err});
        check_val("data_in", ma_data_in, exp_data);
        ma_rd_req = 1'b0;
        ma_wr_req = 1'b0;
      end
    end
    bus_if.bus_ready_io = 1'b0;
    step();
    check_val("done_gap", {31'd0, ma_done}, 32'd0);
    if (txn_bad) resync();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] base;
    logic [3:0]  m;
    int          kind;
    int          off;
    int          rdy;
    bit          wr;

    bus_if.bus_rdata_rom = '0;
    bus_if.bus_rdata_ram = '0;
    bus_if.bus_rdata_io  = '0;
    bus_if.bus_ready_io  = 1'b0;

    // Reset state
    #2;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();

    // Directed cases
    run_txn(1'b0, 32'h0000_0010, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    run_txn(1'b1, 32'h0000_0007, 4'b0001, 32'h0000_00A5, 32'h0,        0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h4000_0002, 4'b0011, 32'h0,        32'h1234_5678, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h8000_0004, 4'b1111, 32'h0,        32'hCAFE_F00D, 4, 1'b0, 1'b1);
    run_txn(1'b0, 32'h8000_0004, 4'b1111, 32'h0,        32'hCAFE_F00D, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h8000_0008, 4'b1111, 32'h0,        32'h0BAD_CAFE, 1 + IO_TIMEOUT, 1'b0, 1'b0);
    run_txn(1'b1, 32'h4000_0000, 4'b1111, 32'h1111_2222, 32'h0,        0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h2000_0000, 4'b1111, 32'h0,        32'h5555_AAAA, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_0013, 4'b0011, 32'h0,        32'h5555_AAAA, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h4000_4000, 4'b1111, 32'h0,        32'h5555_AAAA, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_3FFF, 4'b0001, 32'h0,        32'h8899_AABB, 0, 1'b1, 1'b0);

    // Back-to-back: read request held high through done
    txn_bad = 1'b0;
    bus_if.bus_rdata_ram = 32'h0102_0304;
    ma_addr = 32'h0000_0020; ma_data_mask = 4'b1111; ma_rd_req = 1'b1;
    step(); step(); step();
    check_val("b2b_done1", {31'd0, ma_done}, 32'd1);
    check_val("b2b_data1", ma_data_in, 32'h0102_0304);
    step();
    check_val("b2b_idle_done", {31'd0, ma_done}, 32'd0);
    check_val("b2b_idle_rd", {31'd0, bus_if.bus_rd}, 32'd0);
    step();
    check_val("b2b_strobe2", {31'd0, bus_if.bus_rd}, 32'd1);
    check_val("b2b_addr2", {2'd0, bus_if.bus_addr}, 32'h8);
    step(); step();
    check_val("b2b_done2", {31'd0, ma_done}, 32'd1);
    ma_rd_req = 1'b0;
    step();
    check_val("b2b_after", {31'd0, ma_done}, 32'd0);
    if (txn_bad) resync();

    // Reset asserted during WAIT of an IO read that never completes
    ma_addr = 32'h8000_0000; ma_data_mask = 4'b1111; ma_rd_req = 1'b1;
    step();
    check_val("rstw_strobe", {31'd0, bus_if.bus_rd}, 32'd1);
    step();
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_wait");
    ma_rd_req = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < IO_TIMEOUT + 3; i++) begin
      step();
      check_val("rstw_no_done", {31'd0, ma_done}, 32'd0);
    end

    // Randomized transactions
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 4);
      off  = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       m = 4'b0001;
        1:       m = 4'b0011;
        default: m = 4'b1111;
      endcase
      wr  = 1'($urandom_range(0, 1));
      rdy = 0;
      case (kind)
        0: a = ROM_BASE + (32'($urandom_range(0, 4095)) << 2) + 32'(off);
        1: a = RAM_BASE + (32'($urandom_range(0, 4095)) << 2) + 32'(off);
        2: begin
          a   = IO_BASE + (32'($urandom_range(0, 16383)) << 2) + 32'(off);
          rdy = $urandom_range(2, 3 + IO_TIMEOUT);
        end
        3: a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
        default: begin
          base = ($urandom_range(0, 1) == 0) ? RAM_BASE : ROM_BASE;
          a = base + (($urandom_range(0, 1) == 0) ? 32'h3FFC : 32'h4000) + 32'(off);
        end
      endcase
      run_txn(wr, a, m, $urandom, $urandom, rdy,
              $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop in case something stalls the stimulus
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
